// File: rtl/key_debouncer_if.sv
// ---------------------------------------------------------------------------
// key_debouncer_if : raw button inputs and conditioned outputs of the debouncer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface key_debouncer_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] key;
  logic [WIDTH-1:0] key_db;
  logic [WIDTH-1:0] key_press;
  logic [WIDTH-1:0] key_release;

  modport master (
    output key,
    input  key_db,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key,
    output key_db,
    output key_press,
    output key_release
  );
endinterface

`default_nettype wire

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer : per-bit 2-flop synchroniser, bounce filter and press/release
//                 pulse generator for active-low push-buttons
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_debouncer #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  key_debouncer_if.slave  bus
);

  localparam int            c_CW      = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_ONE     = c_CW'(1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_key_db;
  logic [WIDTH-1:0] r_press;
  logic [WIDTH-1:0] r_release;
  logic [c_CW-1:0]  r_cnt [WIDTH];

  logic [WIDTH-1:0] w_differ;
  logic [WIDTH-1:0] w_expired;

  // Released (all ones) is the safe idle level for the synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= bus.key;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_differ  = r_sync2 ^ r_key_db;
    w_expired = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_expired[i] = (r_cnt[i] == c_CNT_MAX);
    end
  end

  // Any cycle where the synchronised level matches the stable one restarts the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_db  <= '1;
      r_press   <= '0;
      r_release <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_press[i]   <= 1'b0;
        r_release[i] <= 1'b0;
        if (!w_differ[i]) begin
          r_cnt[i] <= '0;
        end else if (w_expired[i]) begin
          r_key_db[i]  <= r_sync2[i];
          r_cnt[i]     <= '0;
          r_press[i]   <= r_key_db[i] & ~r_sync2[i];
          r_release[i] <= ~r_key_db[i] & r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + c_ONE;
        end
      end
    end
  end

  assign bus.key_db      = r_key_db;
  assign bus.key_press   = r_press;
  assign bus.key_release = r_release;

endmodule

`default_nettype wire

// File: doc/key_debouncer.md
# key_debouncer

Input conditioning stage between the DE10-Lite push-buttons and the combinational gate logic fed by `key`. It synchronises each raw active-low button into the clock domain and filters contact bounce. It then presents a clean active-low level plus one-cycle press and release pulses. Downstream logic consumes `key_db` exactly as it would consume raw `key` (pressed = 0).

## Interface
- `WIDTH`, 2: number of independent buttons.
- `DEBOUNCE_CYCLES`, 500000: consecutive cycles a new level must persist before acceptance (10 ms at 50 MHz). Legal range is ≥ 1.
- `clk`, input, 1: system clock, rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `key`, input, WIDTH: raw button pins, active-low, asynchronous to `clk`, may bounce.
- `key_db`, output, WIDTH: debounced level, active-low (1 = released).
- `key_press`, output, WIDTH: one-cycle pulse per bit on accepted 1→0 transition of `key_db`.
- `key_release`, output, WIDTH: one-cycle pulse per bit on accepted 0→1 transition of `key_db`.

## Operation
- Each bit is fully independent: its own 2-flop synchroniser (`sync1`→`sync2`), stable register, and counter of width $clog2(DEBOUNCE_CYCLES+1).
- Reset values, applied asynchronously the moment `reset_n` = 0:
  - `sync1`, `sync2`, `key_db`: all ones (released).
  - Counters: 0.
  - `key_press`, `key_release`: 0.
- Per bit, on each `clk` rising edge:
  - If `sync2` == `key_db`: counter ← 0.
  - Else if counter == DEBOUNCE_CYCLES−1: `key_db` ← `sync2`, counter ← 0, and the matching pulse is asserted for that cycle.
  - Else: counter ← counter+1.
- Any single cycle where `sync2` returns to the stable value clears the counter. The full DEBOUNCE_CYCLES run must then restart.
- All outputs are registered. `key_press` = `key_db_prev` & ~`key_db_next`, registered together with `key_db`. `key_release` is the converse.
- `key_press` and `key_release` are never both 1 on the same bit. Different bits may pulse in the same cycle.
- A held button does not auto-repeat: exactly one press pulse per accepted transition.
- A button held through reset release is accepted like a fresh press: after the nominal latency, `key_db` = 0 and `key_press` pulses once.

## Timing
- Let edge E0 be the first `clk` edge that captures a new steady raw level into `sync1`.
  - `sync2` changes at E1.
  - `key_db` and the pulse update at edge E(DEBOUNCE_CYCLES+1).
  - Latency is therefore DEBOUNCE_CYCLES+1 edges after capture, i.e. DEBOUNCE_CYCLES+2 including the capture edge.
- Pulse width is exactly one `clk` cycle, high in the same cycle `key_db` first shows its new value.
- A glitch shorter than DEBOUNCE_CYCLES cycles at `sync2` produces no change on any output.
- Minimum accepted pulse spacing is DEBOUNCE_CYCLES cycles per bit.
- Reset asserted mid-count discards the count and forces released state with no pulse. Outputs are valid on the first edge after deassertion.
- No combinational path from `key` to any output.

## Test plan
Benches run with DEBOUNCE_CYCLES = 4, WIDTH = 2.
- **Reset:**
  - Stimulus: hold `reset_n` = 0 with `key` = 2'b00.
  - Required response: `key_db` = 2'b11 and pulses 0 throughout. After release with `key` still 00, `key_db` = 00 and `key_press` = 11 for one cycle, at edge 5 after the capture edge.
- **Clean press/release:**
  - Stimulus: `key[0]` 1→0, held 20 cycles, then 0→1.
  - Required response: `key_db[0]` falls 5 edges after capture with a single `key_press[0]` pulse. On release it rises 5 edges later with a single `key_release[0]` pulse. Bit 1 stays 1 with no pulses.
- **Bounce rejection:**
  - Stimulus: `key[1]` toggles 0,1,0,1 with 3-cycle segments, then holds 0.
  - Required response: no output activity during the bouncing. `key_db[1]` = 0 and one `key_press[1]` occur 5 edges after the final steady capture.
- **Exact threshold:**
  - Stimulus: a 3-cycle low pulse on `key[0]`, then separately a 4-cycle low pulse.
  - Required response: the 3-cycle pulse is ignored. The 4-cycle pulse is accepted, followed later by a release pulse.
- **Simultaneous bits:**
  - Stimulus: `key` = 11→00 on the same edge.
  - Required response: `key_press` = 2'b11 in one cycle. No auto-repeat during a 50-cycle hold.
- **Reset mid-count:**
  - Stimulus: assert `reset_n` = 0 two cycles into a valid press.
  - Required response: `key_db` = 11 immediately, with no pulse during reset.
